// File: rtl/master_port.sv
// ---------------------------------------------------------------------------
// master_port
//
// Initiator-side serial bus port. Takes one parallel request from a master
// device, requests the system bus from the arbiter, shifts the address and
// (for writes) the write data out LSB-first, and for reads collects the
// slave's serial response. The bus request is released while a slave holds a
// read in split.
//
// Optional feature (compile-time macro):
//   MASTER_TIMEOUT_EN - read-wait watchdog. When defined, a read that sees no
//                       svalid for TIMEOUT consecutive RDATA cycles completes
//                       with ddone=derr=1 and drdata left unchanged. When not
//                       defined, derr is tied low and reads wait forever.
//
// Parameters:
//   ADDR_WIDTH - address bits shifted per transaction
//   DATA_WIDTH - data bits per transaction (at least 3)
//   TIMEOUT    - read-wait watchdog limit in cycles (MASTER_TIMEOUT_EN only)
//
// Ports:
//   clk, rstn            - clock (rising edge), asynchronous active-low reset
//   dvalid/dmode         - device request valid, 0 read / 1 write
//   daddr/dwdata         - request address and write data
//   dready               - port idle; request accepted on dvalid & dready
//   ddone                - one-cycle completion pulse
//   drdata               - last read result, held until the next read completes
//   derr                 - read timed out (coincident with ddone)
//   mbreq/mbgrant        - bus request to / grant from the arbiter
//   mwdata/mvalid/mmode  - serial address/write data, its valid, latched mode
//   mrdata/svalid        - serial read data from the slave and its valid
//   sready/ssplit        - target slave ready, slave splitting the read
// ---------------------------------------------------------------------------
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic                  ddone,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  derr,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WDATA,
        RDATA,
        SPLIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Address and write data are loaded side by side so a single right shift
    // walks through the address first and then straight into the data.
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] out_shift;

    // Holds the first DATA_WIDTH-1 received bits; the last bit goes straight
    // from mrdata into drdata on the completing edge.
    logic [DATA_WIDTH-2:0] in_shift;
    logic [DATA_WIDTH-1:0] drdata_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  mode_q;

    // Control strobes produced by the FSM for the datapath
    logic accept;
    logic shift_out;
    logic capture;
    logic cnt_clr;
    logic cnt_inc;
    logic read_done;
    logic timed_out;
    logic tmo_expire;

    // State register; reset drops any in-flight transfer without a ddone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. Outputs depend only on state so the
    // bus sees clean, registered-state-derived handshakes.
    always_comb begin
        state_next = state;
        dready     = 1'b0;
        mbreq      = 1'b0;
        mvalid     = 1'b0;
        ddone      = 1'b0;
        accept     = 1'b0;
        shift_out  = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        read_done  = 1'b0;
        timed_out  = 1'b0;

        case (state)
            IDLE: begin
                dready = 1'b1;
                if (dvalid) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end

            REQ: begin
                mbreq = 1'b1;
                if (mbgrant && sready) begin
                    cnt_clr    = 1'b1;
                    state_next = ADDR;
                end
            end

            ADDR: begin
                mbreq     = 1'b1;
                mvalid    = 1'b1;
                shift_out = 1'b1;
                if (bit_cnt == ADDR_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = mode_q ? WDATA : RDATA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            WDATA: begin
                mbreq     = 1'b1;
                mvalid    = 1'b1;
                shift_out = 1'b1;
                if (bit_cnt == DATA_LAST) begin
                    state_next = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            // A split is only honoured before the first data bit arrives;
            // once the slave has started answering it must finish the word.
            RDATA: begin
                mbreq = 1'b1;
                if (svalid) begin
                    capture = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        read_done  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if ((bit_cnt == '0) && ssplit) begin
                    state_next = SPLIT;
                end else if (tmo_expire) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end

            // Bus released; the slave's first data bit re-enters RDATA.
            SPLIT: begin
                if (svalid) begin
                    capture    = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = RDATA;
                end
            end

            DONE: begin
                ddone      = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching, serial shifting and read assembly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_shift <= '0;
            in_shift  <= '0;
            drdata_q  <= '0;
            bit_cnt   <= '0;
            mode_q    <= 1'b0;
        end else begin
            if (accept) begin
                out_shift <= {dwdata, daddr};
                mode_q    <= dmode;
            end else if (shift_out) begin
                out_shift <= {1'b0, out_shift[ADDR_WIDTH+DATA_WIDTH-1:1]};
            end

            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (capture) begin
                in_shift <= {mrdata, in_shift[DATA_WIDTH-2:1]};
            end

            if (read_done) begin
                drdata_q <= {mrdata, in_shift};
            end
        end
    end

`ifdef MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Watchdog counts silent RDATA cycles. Split cycles freeze it (the slave
    // is legitimately busy) and any svalid restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == RDATA) begin
                if (svalid) begin
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else if (state != SPLIT) begin
                tmo_cnt <= '0;
            end
            err_q <= timed_out;
        end
    end

    // The count reaches TIMEOUT on the edge that moves us into DONE.
    assign tmo_expire = (tmo_cnt == TMO_LAST);
    assign derr       = ddone & err_q;
`else
    logic unused_timeout;

    assign tmo_expire     = 1'b0;
    assign derr           = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // mmode only reflects the latched mode while a transaction is in flight.
    assign drdata = drdata_q;
    assign mwdata = mvalid & out_shift[0];
    assign mmode  = mode_q & (state != IDLE);

endmodule

// File: doc/master_port.md
# master_port

Initiator-side serial bus port that turns one parallel device request into a bit-serial transaction on the system bus. It requests the bus from the arbiter and shifts the address, then write data, to the slave port LSB-first. For reads it collects the slave's serial response, releasing the bus while a slave holds the transfer in split. It sits between a master device (CPU/testbench/DMA) and the arbiter/address-decoder fabric, mirroring the slave-side port.

## Interface
- ADDR_WIDTH, 12, address bits shifted per transaction
- DATA_WIDTH, 8, data bits per transaction
- TIMEOUT, 256, read-wait watchdog limit in cycles (used only with MASTER_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- dvalid  in  1  device request valid
- dmode  in  1  0 read, 1 write
- daddr  in  ADDR_WIDTH  request address
- dwdata  in  DATA_WIDTH  write data
- dready  out  1  port idle, request accepted when dvalid&dready
- ddone  out  1  one-cycle completion pulse
- drdata  out  DATA_WIDTH  read result, valid from ddone, held until next read completes
- derr  out  1  one-cycle, coincident with ddone, read timed out
- mbreq  out  1  bus request to arbiter
- mbgrant  in  1  bus grant from arbiter
- mwdata  out  1  serial address/write data
- mmode  out  1  latched dmode during transaction
- mvalid  out  1  mwdata valid
- mrdata  in  1  serial read data from slave
- svalid  in  1  mrdata valid
- sready  in  1  target slave ready
- ssplit  in  1  slave splitting current read

## Operation
- States: IDLE, REQ, ADDR, WDATA, RDATA, SPLIT, DONE.
- IDLE: dready=1. On dvalid, latch daddr/dwdata/dmode, go to REQ.
- REQ: mbreq=1. On mbgrant&sready, go to ADDR and clear the bit counter. Otherwise wait indefinitely.
- ADDR: mvalid=1, mwdata=addr[cnt], cnt 0..ADDR_WIDTH-1. After the last bit, go to WDATA if write, else RDATA.
- WDATA: mvalid=1, mwdata=wdata[cnt], DATA_WIDTH cycles, then DONE.
- RDATA: mvalid=0. Each svalid cycle captures mrdata into bit cnt (LSB-first). When DATA_WIDTH bits are captured, go to DONE.
- In RDATA with zero bits captured and ssplit=1 (without svalid), go to SPLIT.
- SPLIT: mbreq=0, mvalid=0. On svalid, capture bit 0 and return to RDATA with mbreq=1.
- DONE: ddone=1, mbreq=0, drdata updated on reads. Next cycle IDLE.
- mmode is held from REQ through DONE.
- mbreq stays 1 from REQ through RDATA, except in SPLIT. Grant drop mid-transfer is ignored; the arbiter does not preempt.
- ssplit is ignored outside the RDATA zero-bit condition.
- Reset (any state) forces IDLE immediately. The in-flight transfer is discarded with no ddone.
- Output reset values: dready=1, all other outputs 0, drdata=0.

## Timing
- Cycle 0 is the dvalid&dready cycle. Cycle 1 is REQ.
- With grant&sready seen at cycle 1: address bits occupy cycles 2..ADDR_WIDTH+1.
- Write: data bits follow the address, then ddone at cycle ADDR_WIDTH+DATA_WIDTH+2 (22 at defaults).
- Read: ddone is one cycle after the edge capturing the last svalid bit.
- Each extra REQ wait cycle adds exactly one cycle of latency.
- Back-to-back requests: next acceptance is no earlier than the cycle after DONE.

## Configuration
- MASTER_TIMEOUT_EN defined:
  - A counter increments each RDATA cycle without svalid and resets on svalid.
  - On reaching TIMEOUT: go to DONE with ddone=1 and derr=1; drdata is unchanged.
  - SPLIT cycles are not counted.
- Undefined: no counter, derr tied 0, RDATA waits indefinitely.

## Test plan
- Write daddr=0x0A5, dwdata=0x3C, grant and sready high -> mwdata over cycles 2..13 = 1,0,1,0,0,1,0,1,0,0,0,0; cycles 14..21 = 0,0,1,1,1,1,0,0; ddone at cycle 22.
- Read daddr=0x010, slave returns 0xA5 LSB-first after a 3-cycle gap with svalid gaps mid-word -> drdata=0xA5, ddone once, mvalid=0 during RDATA.
- mbgrant delayed 5 cycles, sready low 2 further cycles -> no mvalid until both high, then same bit sequence, latency +7.
- Read with ssplit pulsed before data -> mbreq drops in SPLIT, rises on first svalid; drdata=0x5A for slave data 0x5A.
- rstn low at cycle 6 of ADDR -> all outputs at reset values immediately; no ddone; next request completes normally.
- MASTER_TIMEOUT_EN, TIMEOUT=16, slave silent -> ddone=derr=1 16 cycles after entering RDATA, drdata unchanged; without the macro, no ddone after 1000 cycles.
